// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state and class encodings,
// opcode/funct constants, rf write-data selects and the strobe bundle.
package mc_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } mc_state_e;

  typedef enum logic [2:0] {
    CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR, CL_ILLEGAL
  } mc_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef struct packed {
    logic       im_req;
    logic       ir_enable;
    logic       dm_req;
    logic       dm_write_enable;
    logic       rf_write_enable;
    logic [1:0] rf_wd_sel;
    logic       pc_enable;
  } mc_strobe_t;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [31:0] instr,
  output mc_class_e   cls
);

  logic [5:0] op, fn;
  logic       unused_instr_bits;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    cls = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_SLL: cls = CL_ALU;
          FN_JR:                    cls = CL_JR;
          default:                  cls = CL_ILLEGAL;
        endcase
      end
      OP_ORI, OP_LUI: cls = CL_ALU;
      OP_LW:          cls = CL_LW;
      OP_SW:          cls = CL_SW;
      OP_BEQ:         cls = CL_BEQ;
      OP_J:           cls = CL_J;
      OP_JAL:         cls = CL_JAL;
      default:        cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with wait-stated memories, counts retirements and traps on errors.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  output logic               im_req,
  input  logic               im_ack,
  output logic               ir_enable,
  output logic               dm_req,
  output logic               dm_write_enable,
  input  logic               dm_ack,
  output logic               rf_write_enable,
  output logic [1:0]         cm_rf_write_data,
  output logic               pc_enable,
  output logic [COUNT_W-1:0] retire_count,
  output logic               trap,
  output logic [2:0]         state
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  mc_state_e         st;
  mc_class_e         cls;
  mc_strobe_t        stb;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;

  mc_decode u_decode (.instr(instr), .cls(cls));

  // wait_cnt holds the unacked cycles already spent, so an unacked cycle at
  // MEM_TIMEOUT-1 is the MEM_TIMEOUT-th one without a response.
  if (MEM_TIMEOUT > 0) begin : g_timeout
    assign wait_expired = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  end else begin : g_no_timeout
    assign wait_expired = 1'b0;
  end

  // Strobes decode from the registered state so an async reset drops them at once.
  always_comb begin
    stb = '0;
    case (st)
      ST_FETCH: begin
        stb.im_req    = 1'b1;
        stb.ir_enable = im_ack;
      end
      ST_EXEC: stb.pc_enable = (cls == CL_BEQ) || (cls == CL_J) || (cls == CL_JR);
      ST_MEM: begin
        stb.dm_req          = 1'b1;
        stb.dm_write_enable = (cls == CL_SW);
        stb.pc_enable       = dm_ack && (cls == CL_SW);
      end
      ST_WB: begin
        stb.rf_write_enable = 1'b1;
        stb.pc_enable       = 1'b1;
        stb.rf_wd_sel       = (cls == CL_LW)  ? WD_DM  :
                              (cls == CL_JAL) ? WD_PC4 : WD_ALU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= ST_IDLE;
      wait_cnt     <= '0;
      retire_count <= '0;
    end else begin
      if (stb.pc_enable) retire_count <= retire_count + COUNT_W'(1);
      case (st)
        ST_IDLE: begin
          st       <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_FETCH: begin
          if (im_ack) begin
            st       <= ST_DECODE;
            wait_cnt <= '0;
          end else if (wait_expired) st <= ST_TRAP;
          else wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_DECODE: begin
          st       <= (cls == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
          wait_cnt <= '0;
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          case (cls)
            CL_LW, CL_SW:         st <= ST_MEM;
            CL_ALU, CL_JAL:       st <= ST_WB;
            CL_BEQ, CL_J, CL_JR:  st <= ST_FETCH;
            default:              st <= ST_TRAP;
          endcase
        end
        ST_MEM: begin
          if (dm_ack) begin
            wait_cnt <= '0;
            st       <= (cls == CL_LW) ? ST_WB : (cls == CL_SW) ? ST_FETCH : ST_TRAP;
          end else if (wait_expired) st <= ST_TRAP;
          else wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_WB: begin
          st       <= ST_FETCH;
          wait_cnt <= '0;
        end
        default: st <= ST_TRAP;
      endcase
    end
  end

  assign im_req           = stb.im_req;
  assign ir_enable        = stb.ir_enable;
  assign dm_req           = stb.dm_req;
  assign dm_write_enable  = stb.dm_write_enable;
  assign rf_write_enable  = stb.rf_write_enable;
  assign cm_rf_write_data = stb.rf_wd_sel;
  assign pc_enable        = stb.pc_enable;
  assign trap             = (st == ST_TRAP);
  assign state            = st;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: table vectors, randomized instructions against a phase-level
// model, and hand sequences for reset, trap, timeout and counter wrap.
module tb_mc_control;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_JAL = 5, K_JR = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint exp_ret_a = 0;

  logic        rst_a, im_ack_a, dm_ack_a;
  logic [31:0] instr_a;
  logic        im_req_a, ir_en_a, dm_req_a, dm_we_a, rf_we_a, pc_en_a, trap_a;
  logic [1:0]  sel_a;
  logic [31:0] ret_a;
  logic [2:0]  st_a;

  logic        rst_b, im_ack_b, dm_ack_b;
  logic [31:0] instr_b;
  logic        im_req_b, ir_en_b, dm_req_b, dm_we_b, rf_we_b, pc_en_b, trap_b;
  logic [1:0]  sel_b;
  logic [3:0]  ret_b;
  logic [2:0]  st_b;

  mc_control dut_a (
    .clk(clk), .rst(rst_a), .instr(instr_a), .im_req(im_req_a), .im_ack(im_ack_a),
    .ir_enable(ir_en_a), .dm_req(dm_req_a), .dm_write_enable(dm_we_a), .dm_ack(dm_ack_a),
    .rf_write_enable(rf_we_a), .cm_rf_write_data(sel_a), .pc_enable(pc_en_a),
    .retire_count(ret_a), .trap(trap_a), .state(st_a)
  );

  mc_control #(.MEM_TIMEOUT(4), .COUNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .instr(instr_b), .im_req(im_req_b), .im_ack(im_ack_b),
    .ir_enable(ir_en_b), .dm_req(dm_req_b), .dm_write_enable(dm_we_b), .dm_ack(dm_ack_b),
    .rf_write_enable(rf_we_b), .cm_rf_write_data(sel_b), .pc_enable(pc_en_b),
    .retire_count(ret_b), .trap(trap_b), .state(st_b)
  );

  typedef struct {
    int cycles; int pc_en; int ir_en; int rf_we; int sel; int dm_req; int dm_we; int bad_sel;
  } obs_t;

  typedef struct {
    logic [31:0] instr; int wi; int wd; int cycles; int rf; int sel; int dmreq; int dmwe;
  } vec_t;

  int trace[$];
  int exp_trace[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction on dut_a from FETCH until its pc_enable pulse.
  task automatic run(input logic [31:0] ins, input int wi, input int wd, input bit spur,
                     output obs_t o);
    int iw, dw;
    o = '{default: 0};
    iw = 0; dw = 0;
    trace.delete();
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) instr_a = ins;
      im_ack_a = im_req_a ? (iw >= wi) : (spur && ($urandom_range(0, 1) == 1));
      dm_ack_a = dm_req_a ? (dw >= wd) : (spur && ($urandom_range(0, 1) == 1));
      #1;
      if (im_req_a && !im_ack_a) iw++;
      if (dm_req_a && !dm_ack_a) dw++;
      trace.push_back(int'(st_a));
      o.cycles++;
      o.pc_en  += pc_en_a ? 1 : 0;
      o.ir_en  += ir_en_a ? 1 : 0;
      o.rf_we  += rf_we_a ? 1 : 0;
      o.dm_req += dm_req_a ? 1 : 0;
      o.dm_we  += dm_we_a ? 1 : 0;
      if (rf_we_a) o.sel = int'(sel_a);
      if (sel_a != 2'd0 && st_a != 3'd5) o.bad_sel++;
      if (pc_en_a) break;
    end
  endtask

  // Expected phase sequence built from the instruction class and wait counts.
  task automatic model(input int k, input int wi, input int wd, output obs_t e);
    bit mem, wb;
    mem = (k == K_LW) || (k == K_SW);
    wb  = (k == K_ALU) || (k == K_LW) || (k == K_JAL);
    e = '{default: 0};
    exp_trace.delete();
    repeat (wi + 1) exp_trace.push_back(1);
    exp_trace.push_back(2);
    exp_trace.push_back(3);
    if (mem) repeat (wd + 1) exp_trace.push_back(4);
    if (wb) exp_trace.push_back(5);
    e.cycles = exp_trace.size();
    e.pc_en  = 1;
    e.ir_en  = 1;
    e.rf_we  = wb ? 1 : 0;
    e.dm_req = mem ? wd + 1 : 0;
    e.dm_we  = (k == K_SW) ? wd + 1 : 0;
    e.sel    = (k == K_LW) ? 1 : (k == K_JAL) ? 2 : 0;
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t e);
    chk({tag, " cycles"}, o.cycles, e.cycles);
    chk({tag, " pc_en"}, o.pc_en, e.pc_en);
    chk({tag, " ir_en"}, o.ir_en, e.ir_en);
    chk({tag, " rf_we"}, o.rf_we, e.rf_we);
    chk({tag, " sel"}, o.sel, e.sel);
    chk({tag, " dm_req"}, o.dm_req, e.dm_req);
    chk({tag, " dm_we"}, o.dm_we, e.dm_we);
    chk({tag, " sel_outside_wb"}, o.bad_sel, 0);
    chk({tag, " retire"}, ret_a, exp_ret_a);
    exp_ret_a++;
  endtask

  function automatic logic [31:0] gen(input int k);
    logic [31:0] r, v;
    r = $urandom;
    case (k)
      K_ALU: begin
        case ($urandom_range(0, 4))
          0:       v = {6'b000000, r[25:6], 6'b100001};
          1:       v = {6'b000000, r[25:6], 6'b100011};
          2:       v = {6'b000000, r[25:6], 6'b000000};
          3:       v = {6'b001101, r[25:0]};
          default: v = {6'b001111, r[25:0]};
        endcase
      end
      K_LW:    v = {6'b100011, r[25:0]};
      K_SW:    v = {6'b101011, r[25:0]};
      K_BEQ:   v = {6'b000100, r[25:0]};
      K_J:     v = {6'b000010, r[25:0]};
      K_JAL:   v = {6'b000011, r[25:0]};
      default: v = {6'b000000, r[25:6], 6'b001000};
    endcase
    return v;
  endfunction

  initial begin
    vec_t tbl[12];
    obs_t o, e;
    int k, wi, wd, n, bad;
    string tag;

    tbl[0]  = '{32'h00221821, 0, 0, 4, 1, 0, 0, 0};  // addu
    tbl[1]  = '{32'h8C220004, 0, 3, 8, 1, 1, 4, 0};  // lw, 3 data wait states
    tbl[2]  = '{32'hAC220004, 0, 0, 4, 0, 0, 1, 1};  // sw, immediate ack
    tbl[3]  = '{32'h10220003, 0, 0, 3, 0, 0, 0, 0};  // beq
    tbl[4]  = '{32'h0C000010, 0, 0, 4, 1, 2, 0, 0};  // jal
    tbl[5]  = '{32'h03E00008, 0, 0, 3, 0, 0, 0, 0};  // jr
    tbl[6]  = '{32'h34220005, 2, 0, 6, 1, 0, 0, 0};  // ori, 2 fetch waits
    tbl[7]  = '{32'h08000004, 1, 0, 4, 0, 0, 0, 0};  // j, 1 fetch wait
    tbl[8]  = '{32'h3C011234, 0, 0, 4, 1, 0, 0, 0};  // lui
    tbl[9]  = '{32'h00000000, 0, 0, 4, 1, 0, 0, 0};  // nop
    tbl[10] = '{32'h00221823, 0, 0, 4, 1, 0, 0, 0};  // subu
    tbl[11] = '{32'hAC220008, 0, 2, 6, 0, 0, 3, 3};  // sw, 2 data waits

    rst_a = 1'b0; rst_b = 1'b0;
    im_ack_a = 1'b0; dm_ack_a = 1'b0; instr_a = '0;
    im_ack_b = 1'b0; dm_ack_b = 1'b0; instr_b = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset state", st_a, 0);
    chk("reset strobes", {im_req_a, ir_en_a, dm_req_a, dm_we_a, rf_we_a, sel_a, pc_en_a}, 0);
    chk("reset retire", ret_a, 0);
    chk("reset trap", trap_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("idle after release", st_a, 0);

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].instr, tbl[i].wi, tbl[i].wd, 1'b0, o);
      e = '{default: 0};
      e.cycles = tbl[i].cycles; e.pc_en = 1; e.ir_en = 1; e.rf_we = tbl[i].rf;
      e.sel = tbl[i].sel; e.dm_req = tbl[i].dmreq; e.dm_we = tbl[i].dmwe;
      tag = $sformatf("vec%0d", i);
      compare(tag, o, e);
    end

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 6);
      wi = $urandom_range(0, 4);
      wd = $urandom_range(0, 4);
      run(gen(k), wi, wd, 1'b1, o);
      model(k, wi, wd, e);
      tag = $sformatf("rnd%0d k%0d", i, k);
      compare(tag, o, e);
      bad = -1;
      for (int j = 0; j < trace.size() && j < exp_trace.size(); j++)
        if (bad < 0 && trace[j] != exp_trace[j]) bad = j;
      chk({tag, " trace_mismatch_at"}, bad, -1);
    end

    // Reset while a load is waiting in MEM.
    @(negedge clk);
    instr_a = 32'h8C220004; im_ack_a = 1'b1; dm_ack_a = 1'b0;
    n = 0;
    while (st_a != 3'd4 && n < 8) begin
      @(negedge clk);
      im_ack_a = 1'b0;
      n++;
    end
    #1;
    chk("midmem state", st_a, 4);
    chk("midmem dm_req", dm_req_a, 1);
    #1 rst_a = 1'b0;
    #1;
    chk("midmem rst state", st_a, 0);
    chk("midmem rst strobes", {im_req_a, ir_en_a, dm_req_a, dm_we_a, rf_we_a, sel_a, pc_en_a}, 0);
    chk("midmem rst retire", ret_a, 0);
    exp_ret_a = 0;
    @(negedge clk);
    rst_a = 1'b1;
    #1 chk("post rst idle", st_a, 0);
    @(negedge clk);
    #1 chk("post rst fetch", st_a, 1);

    run(32'h00221821, 0, 0, 1'b0, o);
    model(K_ALU, 0, 0, e);
    compare("addu after rst", o, e);

    // Illegal opcode traps one cycle after DECODE and stays there.
    @(negedge clk);
    instr_a = 32'hFC000000; im_ack_a = 1'b1; dm_ack_a = 1'b0;
    #1 chk("illegal ir_en", ir_en_a, 1);
    @(negedge clk);
    im_ack_a = 1'b0;
    #1 chk("illegal decode", st_a, 2);
    @(negedge clk);
    #1 chk("illegal trap state", st_a, 7);
    chk("illegal trap flag", trap_a, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      im_ack_a = 1'b1; dm_ack_a = 1'b1;
      #1;
      if ({im_req_a, ir_en_a, dm_req_a, dm_we_a, rf_we_a, pc_en_a} != 6'd0 || sel_a != 2'd0 ||
          st_a != 3'd7 || !trap_a) bad++;
    end
    chk("trap held quiet", bad, 0);
    chk("trap retire frozen", ret_a, exp_ret_a);

    // Small instance: 16 nops wrap a 4-bit counter, then a fetch timeout.
    @(negedge clk);
    instr_b = 32'h0; im_ack_b = 1'b1; rst_b = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (pc_en_b) begin
        n++;
        if (n == 16) begin
          chk("wrap before last", ret_b, 15);
          break;
        end
      end
    end
    chk("wrap pulses", n, 16);
    @(negedge clk);
    im_ack_b = 1'b0;
    #1 chk("wrap to zero", ret_b, 0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (st_b == 3'd7) break;
      if (im_req_b) n++;
      @(negedge clk);
      #1;
    end
    chk("timeout req cycles", n, 4);
    chk("timeout trap", trap_b, 1);
    chk("timeout strobes", {im_req_b, ir_en_b, dm_req_b, dm_we_b, rf_we_b, sel_b, pc_en_b}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
